// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg -- shared definitions for the multi-channel timer.
//   chan_state_t  : per-channel FSM state (IDLE, RUN)
//   DEF_NCH       : default number of channels
//   DEF_WIDTH     : default counter / terminal-value width
//   DEF_PRESCALE  : default shared tick divider
package multi_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int DEF_NCH      = 4;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_PRESCALE = 8;

endpackage

// File: rtl/timer_channel.sv
// timer_channel -- one independent timer channel (IDLE/RUN FSM).
//   clk, rstn : clock, asynchronous active-low reset
//   tick      : advance enable shared by all channels
//   start     : start/restart strobe; latches load_val and periodic
//   stop      : abort strobe; wins over start and over expiry
//   periodic  : 1 = reload at expiry, 0 = one-shot
//   load_val  : terminal value T; expiry after T+1 ticks
//   busy      : high while in RUN
//   done      : registered one-cycle expiry pulse
//   count     : current counter value, never above T
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    chan_state_t      state,   state_n;
    logic [WIDTH-1:0] cnt_q,   cnt_n;
    logic [WIDTH-1:0] term_q,  term_n;
    logic             mode_q,  mode_n;
    logic             done_q,  done_n;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt_q  <= '0;
            term_q <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt_q  <= cnt_n;
            term_q <= term_n;
            mode_q <= mode_n;
            done_q <= done_n;
        end
    end

    // NOTE: every variable gets a default before any branch; otherwise a
    // path that skips an assignment would infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_q;
        term_n  = term_q;
        mode_n  = mode_q;
        done_n  = 1'b0;

        if (stop) begin
            // Harmless in IDLE: count is already 0 there.
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start) begin
            state_n = RUN;
            cnt_n   = '0;
            term_n  = load_val;
            mode_n  = periodic;
        end else if (state == RUN && tick) begin
            // Equality (not overflow) ends the period, so count <= T always
            // and the WIDTH-bit counter can never wrap.
            if (cnt_q == term_q) begin
                cnt_n  = '0;
                done_n = 1'b1;
                if (!mode_q) begin
                    state_n = IDLE;
                end
            end else begin
                cnt_n = cnt_q + WIDTH'(1);
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = done_q;
    assign count = cnt_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer -- NCH independent timers sharing one advance tick.
//   clk, rstn : clock, asynchronous active-low reset
//   start     : [NCH] per-channel start/restart strobe
//   stop      : [NCH] per-channel abort strobe
//   periodic  : [NCH] per-channel mode, sampled at start
//   load_val  : [NCH*WIDTH] terminal values, channel i at [i*WIDTH +: WIDTH]
//   busy      : [NCH] channel in RUN
//   done      : [NCH] one-cycle expiry pulse
//   count     : [NCH*WIDTH] current counter values
// Build option: define MULTI_TIMER_PRESCALER_EN to divide the tick by
// PRESCALE with a free-running shared prescaler; otherwise tick is always 1.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       periodic,
    input  logic [NCH*WIDTH-1:0] load_val,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH*WIDTH-1:0] count
);

    logic tick;

`ifdef MULTI_TIMER_PRESCALER_EN
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt;

    // Free-running regardless of channel activity, so the first tick after a
    // start lands anywhere from 1 to PRESCALE cycles later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_W'(PRESCALE - 1)) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));
`else
    // PRESCALE has no meaning without the prescaler; keep it referenced.
    logic unused_prescale;
    assign unused_prescale = (PRESCALE > 1);
    assign tick            = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .tick     (tick),
            .start    (start[i]),
            .stop     (stop[i]),
            .periodic (periodic[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .busy     (busy[i]),
            .done     (done[i]),
            .count    (count[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer -- directed self-checking bench for multi_timer.
// Edge numbering: the edge that samples a start strobe is edge 0 of that
// scenario; outputs are checked 1 ns after each rising edge.
// Build with MULTI_TIMER_PRESCALER_EN for the prescaled scenario (PRESCALE=4);
// without it the cycle-exact scenarios are run.
module tb_multi_timer;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;
    localparam int PS    = 4;

    logic                 clk;
    logic                 rstn;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       periodic;
    logic [NCH*WIDTH-1:0] load_val;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic [NCH*WIDTH-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    multi_timer #(
        .NCH      (NCH),
        .WIDTH    (WIDTH),
        .PRESCALE (PS)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lv(input int ch, input logic [WIDTH-1:0] v);
        load_val[ch*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [WIDTH-1:0] cnt_of(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    initial begin
        rstn     = 1'b0;
        start    = '0;
        stop     = '0;
        periodic = '0;
        load_val = '0;
        #12;
        check("reset_busy",  64'(busy),  64'h0);
        check("reset_done",  64'(done),  64'h0);
        check("reset_count", 64'(count), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

`ifdef MULTI_TIMER_PRESCALER_EN
        // ch3 one-shot T=1. Edge n after release has tick when n%4==0.
        // Start sampled at edge 5 -> ticks at 8 (count 1) and 12 (expiry).
        set_lv(3, 16'd1);
        periodic[3] = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (n == 5) start[3] = 1'b1;
            step();
            start = '0;
            if (n >= 5) begin
                check($sformatf("ps_cnt_e%0d", n), 64'(cnt_of(3)),
                      (n >= 8 && n < 12) ? 64'd1 : 64'd0);
                check($sformatf("ps_done_e%0d", n), 64'(done[3]), (n == 12) ? 64'd1 : 64'd0);
                check($sformatf("ps_busy_e%0d", n), 64'(busy[3]), (n < 12) ? 64'd1 : 64'd0);
            end
        end
`else
        // ch0 one-shot T=3
        set_lv(0, 16'd3);
        periodic[0] = 1'b0;
        start[0]    = 1'b1;
        step();
        start = '0;
        check("os_e0_count", 64'(cnt_of(0)), 64'd0);
        check("os_e0_busy",  64'(busy[0]),   64'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("os_count_e%0d", k), 64'(cnt_of(0)), (k <= 3) ? 64'(k) : 64'd0);
            check($sformatf("os_done_e%0d", k),  64'(done[0]),   (k == 4) ? 64'd1 : 64'd0);
            check($sformatf("os_busy_e%0d", k),  64'(busy[0]),   (k < 4) ? 64'd1 : 64'd0);
        end

        // ch1 periodic T=4 for 20 edges; also a stop on idle ch0 is a no-op
        set_lv(1, 16'd4);
        periodic[1] = 1'b1;
        start[1]    = 1'b1;
        stop[0]     = 1'b1;
        step();
        start = '0;
        stop  = '0;
        check("idle_stop_busy0", 64'(busy[0]), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) set_lv(1, 16'd1);  // must be ignored while running
            if (k == 2) periodic[1] = 1'b0;
            step();
            check($sformatf("per_done_e%0d", k),  64'(done[1]),   (k % 5 == 0) ? 64'd1 : 64'd0);
            check($sformatf("per_count_e%0d", k), 64'(cnt_of(1)), 64'(k % 5));
            check($sformatf("per_busy_e%0d", k),  64'(busy[1]),   64'd1);
        end
        stop[1] = 1'b1;
        step();
        stop = '0;
        check("per_stop_busy", 64'(busy[1]), 64'd0);

        // ch2 periodic T=0: done every edge; stop driven in cycle 6
        set_lv(2, 16'd0);
        periodic[2] = 1'b1;
        start[2]    = 1'b1;
        step();
        start = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("t0_done_e%0d", k),  64'(done[2]),   64'd1);
            check($sformatf("t0_count_e%0d", k), 64'(cnt_of(2)), 64'd0);
        end
        stop[2] = 1'b1;
        step();
        stop = '0;
        check("t0_stop_done",  64'(done[2]),   64'd0);
        check("t0_stop_busy",  64'(busy[2]),   64'd0);
        check("t0_stop_count", 64'(cnt_of(2)), 64'd0);
        step();
        check("t0_after_done", 64'(done[2]), 64'd0);

        // ch0 T=9, restart at count 5 with T=2
        set_lv(0, 16'd9);
        periodic[0] = 1'b0;
        start[0]    = 1'b1;
        step();
        start = '0;
        for (int k = 1; k <= 5; k++) step();
        check("rs_pre_count", 64'(cnt_of(0)), 64'd5);
        set_lv(0, 16'd2);
        start[0] = 1'b1;
        step();
        start = '0;
        check("rs_e0_count", 64'(cnt_of(0)), 64'd0);
        check("rs_e0_done",  64'(done[0]),   64'd0);
        check("rs_e0_busy",  64'(busy[0]),   64'd1);
        step();
        check("rs_e1_count", 64'(cnt_of(0)), 64'd1);
        step();
        check("rs_e2_count", 64'(cnt_of(0)), 64'd2);
        check("rs_e2_done",  64'(done[0]),   64'd0);
        step();
        check("rs_e3_done",  64'(done[0]),   64'd1);
        check("rs_e3_count", 64'(cnt_of(0)), 64'd0);
        check("rs_e3_busy",  64'(busy[0]),   64'd0);

        // start+stop together while running: stop wins
        set_lv(0, 16'd3);
        start[0] = 1'b1;
        step();
        start = '0;
        step();
        check("ss_pre_count", 64'(cnt_of(0)), 64'd1);
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        step();
        start = '0;
        stop  = '0;
        check("ss_busy",  64'(busy[0]),   64'd0);
        check("ss_count", 64'(cnt_of(0)), 64'd0);
        check("ss_done",  64'(done[0]),   64'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ss_after_done_e%0d", k), 64'(done[0]), 64'd0);
        end

        // all channels T=1..4, reset pulsed after edge 3
        for (int i = 0; i < NCH; i++) set_lv(i, 16'(i + 1));
        periodic = '0;
        start    = '1;
        step();
        start = '0;
        step();
        check("all_e1_count", 64'(count), 64'h0001_0001_0001_0001);
        step();
        check("all_e2_count", 64'(count), 64'h0002_0002_0002_0000);
        check("all_e2_done",  64'(done),  64'h1);
        step();
        check("all_e3_count", 64'(count), 64'h0003_0003_0000_0000);
        check("all_e3_done",  64'(done),  64'h2);
        check("all_e3_busy",  64'(busy),  64'hC);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy",  64'(busy),  64'h0);
        check("mid_rst_done",  64'(done),  64'h0);
        check("mid_rst_count", 64'(count), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("post_rst_done_e%0d", k),  64'(done),  64'h0);
            check($sformatf("post_rst_busy_e%0d", k),  64'(busy),  64'h0);
            check($sformatf("post_rst_count_e%0d", k), 64'(count), 64'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the per-channel counter and terminal-value width in bits.
REQ-003 The block SHALL have parameter PRESCALE, default 8, giving the shared tick divider (>=2), used only when the prescaler is compiled in.
REQ-004 The block SHALL have port clk, input, 1, the rising-edge system clock.
REQ-005 The block SHALL have port rstn, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, NCH, a per-channel single-cycle start/restart strobe.
REQ-007 The block SHALL have port stop, input, NCH, a per-channel single-cycle abort strobe.
REQ-008 The block SHALL have port periodic, input, NCH, the per-channel mode sampled at start (1 = periodic, 0 = one-shot).
REQ-009 The block SHALL have port load_val, input, NCH*WIDTH, the per-channel terminal value T sampled at start, with channel i at bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port busy, output, NCH, which is high while the channel is in RUN.
REQ-011 The block SHALL have port done, output, NCH, a registered one-cycle expiry pulse per channel.
REQ-012 The block SHALL have port count, output, NCH*WIDTH, giving the current per-channel counter value.

Function
REQ-013 Each channel SHALL be a two-state FSM with states IDLE and RUN.
REQ-014 In IDLE, start=1 SHALL load count=0, latch T and the mode, and enter RUN at that edge.
REQ-015 In RUN, count SHALL increment by 1 on every edge where tick=1 and count<T, and SHALL hold when tick=0.
REQ-016 In RUN, at an edge with tick=1 and count==T, count SHALL go to 0 and done SHALL be high for exactly the following cycle.
REQ-017 At that expiry edge, periodic mode SHALL remain in RUN and one-shot mode SHALL enter IDLE.
REQ-018 Expiry SHALL therefore occur T+1 ticks after the start edge, so the periodic period is T+1 ticks.
REQ-019 With T=0, done SHALL pulse on every tick while in RUN.
REQ-020 start in RUN SHALL restart the channel: count=0, T and the mode re-latched, and no done pulse for that edge.
REQ-021 stop SHALL take priority over start and over expiry: the channel enters IDLE with count=0 and no done pulse.
REQ-022 A stop strobe in IDLE SHALL have no effect.
REQ-023 Changes to load_val or periodic while in RUN SHALL be ignored until the next start.
REQ-024 Channels SHALL be fully independent, and simultaneous events on different channels SHALL all be honoured in the same cycle.
REQ-025 The count SHALL never exceed T, and WIDTH-bit wrap-around SHALL be impossible by construction.

Reset
REQ-026 While rstn=0, every channel SHALL be in IDLE with count=0, T=0, busy=0 and done=0, and the prescaler counter SHALL be 0.
REQ-027 A reset asserted mid-operation SHALL abort all channels immediately, with no done pulse emitted on reset release.

Configuration
REQ-028 The macro MULTI_TIMER_PRESCALER_EN, when defined, SHALL compile in one shared free-running prescaler counting 0..PRESCALE-1 that asserts tick for one cycle when at PRESCALE-1.
REQ-029 The prescaler SHALL run regardless of channel state, so the first tick after start falls anywhere from 1 to PRESCALE cycles after the start edge.
REQ-030 Without MULTI_TIMER_PRESCALER_EN, tick SHALL be constant 1, every channel SHALL advance every cycle, and PRESCALE SHALL be ignored.

Structure
REQ-031 The shared package multi_timer_pkg SHALL hold the channel state enum (IDLE, RUN) and the default parameter constants.
REQ-032 Each channel SHALL be one instance of sub-module timer_channel (params WIDTH; ports clk, rstn, tick, start, stop, periodic, load_val, busy, done, count), generated NCH times, with the prescaler kept in the top level.

Verification
REQ-033 The bench SHALL cover: no prescaler, ch0 one-shot T=3, start at cycle 0 -> count 1,2,3 on cycles 1-3, done high in cycle 4 only, busy low from cycle 4.
REQ-034 The bench SHALL cover: no prescaler, ch1 periodic T=4, run 20 cycles -> done pulses every 5 cycles (cycles 5,10,15,20), busy high throughout.
REQ-035 The bench SHALL cover: ch2 periodic T=0 -> done high every cycle; stop asserted at cycle 6 -> done low from cycle 7, busy=0, count=0.
REQ-036 The bench SHALL cover: ch0 T=9, restart via start at count=5 with new T=2 -> count 0,1,2, then done three cycles after restart; start+stop in the same cycle -> IDLE, no done.
REQ-037 The bench SHALL cover: with MULTI_TIMER_PRESCALER_EN and PRESCALE=4, ch3 one-shot T=1 -> count advances only on prescaler-wrap cycles, and done occurs 2 ticks after start.
REQ-038 The bench SHALL cover: all four channels started together with T=1,2,3,4, with rstn pulsed low at cycle 3 -> all outputs 0 immediately, no done pulse after release.
